// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin output arbiter.
package mux2_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    localparam logic REQ0     = 1'b0;
    localparam logic REQ1     = 1'b1;
    // Requester 1 is treated as the previous winner after reset, so requester 0 wins the first tie.
    localparam logic RST_LAST = REQ1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: the side that did not win last time wins a tie.
module rr_pick2
    import mux2_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic       sel
);

    always_comb begin
        sel = last;
        case (valid)
            2'b01:   sel = REQ0;
            2'b10:   sel = REQ1;
            2'b11:   sel = ~last;
            default: sel = last;
        endcase
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester valid/ready round-robin arbiter with a one-entry registered output.
// Optional grant statistics counters are enabled with the macro MUX2_ARB_STATS_EN.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef MUX2_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in0_valid,
    output logic                 in0_ready,
    input  logic [WIDTH-1:0]     in0_data,
    input  logic                 in1_valid,
    output logic                 in1_ready,
    input  logic [WIDTH-1:0]     in1_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_src,
`ifdef MUX2_ARB_STATS_EN
    output logic [CNT_WIDTH-1:0] grant_cnt0,
    output logic [CNT_WIDTH-1:0] grant_cnt1,
`endif
    output logic                 sel
);

    out_state_t       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_q, last_d;
    logic             load_en;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    genvar gi;

    rr_pick2 u_pick (
        .valid ({in1_valid, in0_valid}),
        .last  (last_q),
        .sel   (sel)
    );

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign mux_data[gi] = sel ? in1_data[gi] : in0_data[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        last_d     = last_q;

        // The register can take a word when empty or when its current word leaves this cycle.
        load_en   = (state_q == ST_EMPTY) || out_ready;
        in0_ready = !rst && load_en && (sel == REQ0);
        in1_ready = !rst && load_en && (sel == REQ1);
        accept    = (in0_ready && in0_valid) || (in1_ready && in1_valid);

        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (out_ready) state_d = accept ? ST_FULL : ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            out_data_d = mux_data;
            out_src_d  = sel;
            last_d     = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_src_q  <= REQ0;
            last_q     <= RST_LAST;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            last_q     <= last_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef MUX2_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [2];
    logic [CNT_WIDTH-1:0] cnt_d [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            // Saturating count of words accepted from requester gi.
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (accept && (sel == 1'(gi)) && (cnt_q[gi] != '1))
                    cnt_d[gi] = cnt_q[gi] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end

            always_ff @(posedge clk) begin
                if (rst) cnt_q[gi] <= '0;
                else     cnt_q[gi] <= cnt_d[gi];
            end
        end
    endgenerate

    assign grant_cnt0 = cnt_q[0];
    assign grant_cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus random traffic against a reference model.
module tb_mux2_rr_arbiter;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in0_valid = 1'b0, in1_valid = 1'b0;
    logic [W-1:0] in0_data = '0, in1_data = '0;
    logic         in0_ready, in1_ready;
    logic         out_valid, out_src, sel;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef MUX2_ARB_STATS_EN
    logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    mux2_rr_arbiter #(
        .WIDTH     (W)
`ifdef MUX2_ARB_STATS_EN
        ,
        .CNT_WIDTH (CW)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in0_data   (in0_data),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .in1_data   (in1_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
`ifdef MUX2_ARB_STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .sel        (sel)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the output slot and the most recent winner.
    logic         m_full;
    logic [W-1:0] m_data;
    logic         m_src;
    logic         m_last;
    int           m_cnt0, m_cnt1;
    int           sat_max = (1 << CW) - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_src  = 1'b0;
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    // One clock of traffic: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic r, input logic v0, input logic [W-1:0] d0,
                        input logic v1, input logic [W-1:0] d1, input logic o);
        logic pick, room, e_rdy0, e_rdy1, won;
        rst = r; in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = o;
        #1;
        // The requester that did not win last time has priority; otherwise whoever is asking.
        if (v0 && v1)  pick = !m_last;
        else if (v0)   pick = 1'b0;
        else if (v1)   pick = 1'b1;
        else           pick = m_last;
        room   = !m_full || o;
        e_rdy0 = !r && room && (pick == 1'b0);
        e_rdy1 = !r && room && (pick == 1'b1);
        won    = (e_rdy0 && v0) || (e_rdy1 && v1);
        chk("sel", {31'd0, sel}, {31'd0, pick});
        chk("in0_ready", {31'd0, in0_ready}, {31'd0, e_rdy0});
        chk("in1_ready", {31'd0, in1_ready}, {31'd0, e_rdy1});

        if (!r && m_full && o)
            $display("xfer t=%0t src=%0d data=0x%02h", $time, m_src, m_data);

        if (r) begin
            model_reset();
        end else if (won) begin
            m_full = 1'b1;
            m_data = pick ? d1 : d0;
            m_src  = pick;
            m_last = pick;
            if (pick) m_cnt1 = (m_cnt1 < sat_max) ? m_cnt1 + 1 : m_cnt1;
            else      m_cnt0 = (m_cnt0 < sat_max) ? m_cnt0 + 1 : m_cnt0;
        end else if (room) begin
            m_full = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("out_data", {24'd0, out_data}, {24'd0, m_data});
        chk("out_src", {31'd0, out_src}, {31'd0, m_src});
`ifdef MUX2_ARB_STATS_EN
        chk("grant_cnt0", {28'd0, grant_cnt0}, m_cnt0);
        chk("grant_cnt1", {28'd0, grant_cnt1}, m_cnt1);
`endif
    endtask

    initial begin
        logic prev_src;
        logic [W-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;

        // Bring the design to a known state before any model comparison.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // Reset held with both requesters active.
        step(1, 1, 8'h01, 1, 8'h02, 1);
        step(1, 1, 8'h01, 1, 8'h02, 1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        step(0, 1, 8'h01, 1, 8'h02, 1);
        chk("first_grant_src", {31'd0, out_src}, 32'd0);
        step(0, 0, 8'h00, 0, 8'h00, 1);

        // Single source streaming.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, vals[i], 0, 8'h00, 1);
            chk("single_data", {24'd0, out_data}, {24'd0, vals[i]});
        end
        step(0, 0, 8'h00, 0, 8'h00, 1);

        // Contention: grants must strictly alternate.
        prev_src = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'hA0 + 8'(i), 1, 8'hB0 + 8'(i), 1);
            if (i > 0) chk("alternate", {31'd0, out_src}, {31'd0, ~prev_src});
            prev_src = out_src;
        end
        step(0, 0, 8'h00, 0, 8'h00, 1);

        // Backpressure on a full register holding 0x5A.
        step(0, 1, 8'h5A, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'h66, 1, 8'h77, 0);
            chk("stall_data", {24'd0, out_data}, 32'h5A);
        end
        step(0, 1, 8'h66, 1, 8'h77, 1);
        chk("resume_src", {31'd0, out_src}, 32'd1);

        // Reset while full under contention.
        step(0, 1, 8'hC1, 1, 8'hD1, 0);
        step(1, 1, 8'hC2, 1, 8'hD2, 0);
        chk("midreset_valid", {31'd0, out_valid}, 32'd0);
        step(0, 1, 8'hC3, 1, 8'hD3, 1);
        chk("post_reset_src", {31'd0, out_src}, 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

`ifdef MUX2_ARB_STATS_EN
        // Saturation of the requester-1 counter.
        step(1, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 1, 8'(i), 1);
        chk("cnt1_saturated", {28'd0, grant_cnt1}, 32'd15);
        chk("cnt0_zero", {28'd0, grant_cnt0}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
